// File: rtl/dht11_reader_pkg.sv
// Shared types and frame layout for the DHT11 single-wire reader.
package dht_pkg;

  typedef enum logic [3:0] {
    IDLE, START_LOW, RELEASE, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH, CHECK, ERROR
  } dht_state_e;

  localparam int FRAME_BITS  = 40;
  localparam int HUM_INT_MSB = 39;
  localparam int HUM_DEC_MSB = 31;
  localparam int TMP_INT_MSB = 23;
  localparam int TMP_DEC_MSB = 15;
  localparam int CSUM_MSB    = 7;

  // Checksum is the mod-256 sum of the four data bytes.
  function automatic logic frame_csum_ok(input logic [FRAME_BITS-1:0] f);
    logic [7:0] sum;
    sum = f[HUM_INT_MSB -: 8] + f[HUM_DEC_MSB -: 8] + f[TMP_INT_MSB -: 8] + f[TMP_DEC_MSB -: 8];
    return sum == f[CSUM_MSB -: 8];
  endfunction

endpackage

// File: rtl/dht11_reader_us_tick_gen.sv
// One-cycle pulse every microsecond; clr restarts the phase so each FSM
// state measures whole microseconds from its entry edge.
module us_tick_gen #(
  parameter int CLK_FREQ_HZ = 50_000_000
) (
  input  logic clk,
  input  logic nRST,
  input  logic clr,
  output logic us_tick
);

  localparam int DIV = (CLK_FREQ_HZ / 1_000_000 > 0) ? CLK_FREQ_HZ / 1_000_000 : 1;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  assign us_tick = (cnt == CW'(DIV - 1));

  always_ff @(posedge clk) begin
    if (!nRST || clr || us_tick) cnt <= '0;
    else                         cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/dht11_reader.sv
// DHT11 master: start pulse, response timing, 40-bit pulse-width decode.
// Define DHT_CHECKSUM_EN to reject frames whose checksum byte mismatches.
import dht_pkg::*;

module dht11_reader #(
  parameter int CLK_FREQ_HZ   = 50_000_000,
  parameter int START_LOW_US  = 18000,
  parameter int BIT_THRESH_US = 40,
  parameter int TIMEOUT_US    = 200
) (
  input  logic                  clk,
  input  logic                  nRST,
  input  logic                  start,
  input  logic                  dht_in,
  output logic                  dht_oe,
  output logic [FRAME_BITS-1:0] tem_data,
  output logic                  data_valid,
  output logic                  busy,
  output logic                  err
);

  localparam logic [14:0] START_CNT = 15'(START_LOW_US);
  localparam logic [14:0] THR_CNT   = 15'(BIT_THRESH_US);
  localparam logic [14:0] TMO_CNT   = 15'(TIMEOUT_US);

  dht_state_e state, state_nx;

  logic [1:0]            sync;
  logic                  prev, cur, rise, fall;
  logic                  us_tick, enter;
  logic [14:0]           us_cnt, us_cnt_nx;
  logic                  timeout, bit_val, csum_ok;
  logic [5:0]            bit_idx;
  logic [FRAME_BITS-1:0] shift_reg;
  logic                  shift_en, idx_clr, ld_frame, set_err, clr_err;

  us_tick_gen #(.CLK_FREQ_HZ(CLK_FREQ_HZ)) u_tick (
    .clk     (clk),
    .nRST    (nRST),
    .clr     (enter),
    .us_tick (us_tick)
  );

  assign cur  = sync[1];
  assign rise = cur & ~prev;
  assign fall = prev & ~cur;

  // Comparisons include the tick landing on this edge.
  assign us_cnt_nx = (us_tick && us_cnt != '1) ? us_cnt + 15'd1 : us_cnt;
  assign timeout   = us_cnt_nx > TMO_CNT;
  assign bit_val   = us_cnt_nx > THR_CNT;

`ifdef DHT_CHECKSUM_EN
  assign csum_ok = frame_csum_ok(shift_reg);
`else
  assign csum_ok = 1'b1;
`endif

  always_comb begin
    state_nx = state;
    shift_en = 1'b0;
    idx_clr  = 1'b0;
    ld_frame = 1'b0;
    set_err  = 1'b0;
    clr_err  = 1'b0;
    case (state)
      IDLE: if (start) begin
        state_nx = START_LOW;
        clr_err  = 1'b1;
      end
      START_LOW: if (us_cnt_nx >= START_CNT) state_nx = RELEASE;
      RELEASE:   if (fall) state_nx = RESP_LOW;  else if (timeout) state_nx = ERROR;
      RESP_LOW:  if (rise) state_nx = RESP_HIGH; else if (timeout) state_nx = ERROR;
      RESP_HIGH: if (fall) begin
        state_nx = BIT_LOW;
        idx_clr  = 1'b1;
      end else if (timeout) state_nx = ERROR;
      BIT_LOW:   if (rise) state_nx = BIT_HIGH;  else if (timeout) state_nx = ERROR;
      BIT_HIGH: if (fall) begin
        shift_en = 1'b1;
        state_nx = (bit_idx == 6'(FRAME_BITS - 1)) ? CHECK : BIT_LOW;
      end else if (timeout) state_nx = ERROR;
      CHECK: if (csum_ok) begin
        ld_frame = 1'b1;
        state_nx = IDLE;
      end else state_nx = ERROR;
      ERROR: begin
        set_err  = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    enter = (state_nx != state);
  end

  always_ff @(posedge clk) begin
    if (!nRST) state <= IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (!nRST) begin
      sync       <= 2'b11;
      prev       <= 1'b1;
      us_cnt     <= '0;
      bit_idx    <= '0;
      shift_reg  <= '0;
      dht_oe     <= 1'b0;
      tem_data   <= '0;
      data_valid <= 1'b0;
      busy       <= 1'b0;
      err        <= 1'b0;
    end else begin
      sync       <= {sync[0], dht_in};
      prev       <= cur;
      us_cnt     <= enter ? '0 : us_cnt_nx;
      dht_oe     <= (state_nx == START_LOW);
      busy       <= (state_nx != IDLE);
      data_valid <= ld_frame;
      if (ld_frame) tem_data <= shift_reg;
      if (clr_err)      err <= 1'b0;
      else if (set_err) err <= 1'b1;
      if (idx_clr)       bit_idx <= '0;
      else if (shift_en) bit_idx <= bit_idx + 6'd1;
      if (shift_en) shift_reg <= {shift_reg[FRAME_BITS-2:0], bit_val};
    end
  end

endmodule

// File: tb/tb_dht11_reader.sv
// Directed bench for dht11_reader with a cycle-exact DHT11 sensor model
// (2 clocks per microsecond, shortened start pulse).
module tb_dht11_reader;

  localparam int DIV = 2;
  localparam int SLU = 100;

  logic        clk = 1'b0, nRST = 1'b0, start = 1'b0, sens = 1'b1;
  logic        dht_in, dht_oe, data_valid, busy, err;
  logic [39:0] tem_data;
  int          n_chk = 0, n_fail = 0, dv_cnt = 0;

  assign dht_in = dht_oe ? 1'b0 : sens;

  always #5 clk = ~clk;

  always @(negedge clk) if (data_valid) dv_cnt++;

  dht11_reader #(
    .CLK_FREQ_HZ(2_000_000), .START_LOW_US(SLU), .BIT_THRESH_US(40), .TIMEOUT_US(200)
  ) dut (
    .clk(clk), .nRST(nRST), .start(start), .dht_in(dht_in), .dht_oe(dht_oe),
    .tem_data(tem_data), .data_valid(data_valid), .busy(busy), .err(err)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  // Accept a start and count the cycles the line is held low by the host.
  task automatic do_start(output int oe_cyc);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    chk("busy_on", 40'(busy), 40'd1);
    chk("err_clr", 40'(err), 40'd0);
    oe_cyc = 0;
    while (dht_oe && oe_cyc < 10 * SLU * DIV) begin
      oe_cyc++;
      tick(1);
    end
  endtask

  // Sensor reply; abort_bit >= 0 pulses nRST in the high phase of that bit.
  task automatic send_frame(input logic [39:0] f, input int w0, input int w1, input int abort_bit);
    tick(20 * DIV);
    sens = 1'b0; tick(80 * DIV);
    sens = 1'b1; tick(80 * DIV);
    for (int i = 0; i < 40; i++) begin
      sens = 1'b0; tick(20 * DIV);
      sens = 1'b1;
      if (i == abort_bit) begin
        tick(10 * DIV);
        nRST = 1'b0;
        tick(1);
        chk("rst_oe",   40'(dht_oe),     40'd0);
        chk("rst_busy", 40'(busy),       40'd0);
        chk("rst_err",  40'(err),        40'd0);
        chk("rst_dv",   40'(data_valid), 40'd0);
        chk("rst_data", tem_data,        40'd0);
        nRST = 1'b1;
        tick(4);
        return;
      end
      tick((f[39-i] ? w1 : w0) * DIV);
    end
    sens = 1'b0; tick(50 * DIV);
    sens = 1'b1; tick(5);
  endtask

  initial begin
    int oe_cyc, dv0, n;
    logic oe_bad;

    tick(3);
    chk("reset_oe",   40'(dht_oe),     40'd0);
    chk("reset_busy", 40'(busy),       40'd0);
    chk("reset_err",  40'(err),        40'd0);
    chk("reset_dv",   40'(data_valid), 40'd0);
    chk("reset_data", tem_data,        40'd0);
    nRST = 1'b1;
    tick(2);

    // Good frame 40% / 25C, plus an ignored start while busy
    dv0 = dv_cnt;
    do_start(oe_cyc);
    chk("oe_len", 40'(oe_cyc), 40'(SLU * DIV));
    start = 1'b1; tick(1); start = 1'b0;
    chk("busy_hold", 40'(busy), 40'd1);
    send_frame(40'h2800190041, 27, 70, -1);
    chk("a_dv",   40'(dv_cnt - dv0), 40'd1);
    chk("a_data", tem_data,          40'h2800190041);
    chk("a_err",  40'(err),          40'd0);
    chk("a_busy", 40'(busy),         40'd0);

    // Bad checksum byte
    dv0 = dv_cnt;
    do_start(oe_cyc);
    send_frame(40'h2800190042, 27, 70, -1);
`ifdef DHT_CHECKSUM_EN
    chk("b_err",  40'(err),          40'd1);
    chk("b_dv",   40'(dv_cnt - dv0), 40'd0);
    chk("b_data", tem_data,          40'h2800190041);
`else
    chk("b_err",  40'(err),          40'd0);
    chk("b_dv",   40'(dv_cnt - dv0), 40'd1);
    chk("b_data", tem_data,          40'h2800190042);
`endif
    chk("b_busy", 40'(busy), 40'd0);

    // Threshold widths: 40 us -> 0, 41 us -> 1
    dv0 = dv_cnt;
    do_start(oe_cyc);
    send_frame(40'h37051A0359, 40, 41, -1);
    chk("thr_data", tem_data,          40'h37051A0359);
    chk("thr_dv",   40'(dv_cnt - dv0), 40'd1);
    chk("thr_err",  40'(err),          40'd0);

    // Silent sensor: RELEASE times out after ~201 us
    do_start(oe_cyc);
    n = 0; oe_bad = 1'b0;
    while (!err && n < 1000) begin
      if (dht_oe) oe_bad = 1'b1;
      n++;
      tick(1);
    end
    chk("silent_err",  40'(err),                     40'd1);
    chk("silent_time", 40'(n >= 395 && n <= 410),    40'd1);
    chk("silent_busy", 40'(busy),                    40'd0);
    chk("silent_oe",   40'(oe_bad | dht_oe),         40'd0);

    // Stuck low after the sensor starts its response
    do_start(oe_cyc);
    tick(20 * DIV);
    sens = 1'b0;
    n = 0;
    while (!err && n < 1000) begin n++; tick(1); end
    chk("stuck_err",  40'(err),    40'd1);
    chk("stuck_busy", 40'(busy),   40'd0);
    chk("stuck_oe",   40'(dht_oe), 40'd0);
    sens = 1'b1;
    tick(10);

    // Reset inside BIT_HIGH of bit 20, then a clean read
    do_start(oe_cyc);
    send_frame(40'h2800190041, 27, 70, 20);
    dv0 = dv_cnt;
    do_start(oe_cyc);
    chk("fresh_oe_len", 40'(oe_cyc), 40'(SLU * DIV));
    send_frame(40'h3C00160557, 27, 70, -1);
    chk("fresh_data", tem_data,          40'h3C00160557);
    chk("fresh_dv",   40'(dv_cnt - dv0), 40'd1);
    chk("fresh_err",  40'(err),          40'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dht11_reader.md
Name: dht11_reader

Overview:
- Single-wire DHT11 protocol master that produces the 40-bit sensor frame consumed by the downstream 7-segment scan driver.
- Layout of tem_data: humidity int [39:32], humidity dec [31:24], temp int [23:16], temp dec [15:8], checksum [7:0].
- Issues the host start pulse, times the sensor response, samples 40 bits by high-pulse width, checks the frame and holds the last good frame.
- The data pin is modelled open-drain: the block only ever drives it low.

Parameters:
- CLK_FREQ_HZ, 50_000_000, system clock frequency; sets the 1 us tick prescale.
- START_LOW_US, 18000, host start-pulse low time.
- BIT_THRESH_US, 40, high-pulse width above which a bit is 1.
- TIMEOUT_US, 200, maximum time in any wait or measure phase before error.

Ports:
- clk  in  1  system clock.
- nRST  in  1  synchronous active-low reset.
- start  in  1  one-cycle request to read the sensor; ignored while busy.
- dht_in  in  1  raw line level from the pad; asynchronous.
- dht_oe  out  1  1 = pull line low, 0 = release to pull-up.
- tem_data  out  40  last accepted frame.
- data_valid  out  1  one-cycle pulse when tem_data is updated.
- busy  out  1  high from start acceptance until return to IDLE.
- err  out  1  sticky error flag; cleared on the next accepted start.

Behaviour:
- Reset: clk, sync, active-low. While nRST=0 at a clk edge:
  - dht_oe=0, tem_data=0, data_valid=0, busy=0, err=0.
  - FSM=IDLE, counters=0, synchronizer=2'b11.
  - Reset mid-transaction aborts immediately; the line is released the next cycle.
- Input: dht_in passes a 2-FF synchronizer. All edge detection uses the synchronized value; a fall is prev=1, cur=0.
- Tick: us_tick pulses one cycle every CLK_FREQ_HZ/1_000_000 clocks. The us counter (15 bit, saturating) clears on every state entry.
- FSM:
  - IDLE: start=1 -> START_LOW with busy=1 and err=0 set on the same edge.
  - START_LOW: dht_oe=1. When us_cnt reaches START_LOW_US -> RELEASE.
  - RELEASE: dht_oe=0. On a synced fall -> RESP_LOW. If us_cnt>TIMEOUT_US -> ERROR.
  - RESP_LOW: on a rise -> RESP_HIGH. Timeout -> ERROR.
  - RESP_HIGH: on a fall -> BIT_LOW with bit_idx=0. Timeout -> ERROR.
  - BIT_LOW: on a rise -> BIT_HIGH. Timeout -> ERROR.
  - BIT_HIGH: on a fall, shift the bit into shift_reg[39:0] MSB-first (bit = us_cnt>BIT_THRESH_US).
    - bit_idx==39 -> CHECK.
    - Otherwise bit_idx+1 -> BIT_LOW.
    - Timeout -> ERROR.
  - CHECK (one cycle): sum = frame[39:32]+[31:24]+[23:16]+[15:8], modulo 256.
    - Match [7:0] -> tem_data<=shift_reg and data_valid=1 on this edge -> IDLE.
    - Mismatch -> ERROR.
  - ERROR (one cycle): err<=1, tem_data unchanged -> IDLE.
- busy drops on the edge entering IDLE. A start in that same cycle is ignored; a start one cycle later is accepted.
- Latency: from start to data_valid is roughly START_LOW_US plus about 4 ms of sensor frame. No fixed cycle count is defined.
- A start during busy has no effect; it is not queued.
- Boundary cases:
  - A high pulse exactly BIT_THRESH_US decodes as 0.
  - The us_cnt comparison uses a tick counted at the edge.
  - Line stuck low or stuck high -> ERROR after TIMEOUT_US. dht_oe is never asserted outside START_LOW.

Optional Feature:
- DHT_CHECKSUM_EN defined: CHECK compares the checksum as above.
- Undefined: CHECK always accepts the frame, updates tem_data and pulses data_valid. err is then set only by timeouts.

Decomposition:
- Package dht_pkg holds:
  - State enum: IDLE, START_LOW, RELEASE, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH, CHECK, ERROR.
  - Frame field offset constants: HUM_INT_MSB=39, TMP_INT_MSB=23, CSUM_MSB=7.
  - FRAME_BITS=40.
- Sub-module us_tick_gen (parameter CLK_FREQ_HZ) produces us_tick; it resets with nRST.

Test Plan:
- Sensor model sends 0x28,0x00,0x19,0x00,0x41 (40%, 25C) -> data_valid pulses once, tem_data=40'h2800190041, err=0, busy falls.
- Same frame with checksum byte 0x42, DHT_CHECKSUM_EN defined -> err=1, no data_valid, tem_data holds 40'h2800190041. With the macro undefined -> tem_data=40'h2800190042.
- Sensor silent (line stays high) after release -> err=1 at about 200 us after release, busy=0, dht_oe=0 throughout.
- dht_oe timing: start pulse -> dht_oe high for exactly 18000 us of ticks (900_000 clocks at 50 MHz), then 0.
- Boundary bit widths: 40 us high -> 0, 41 us -> 1, 70 us -> 1, 27 us -> 0.
- nRST low during BIT_HIGH of bit 20 -> next cycle all outputs are at reset values. A fresh start then reads a full frame correctly.
